// File: rtl/input_conditioner.sv
// Conditions the board's raw slide switches and push buttons for switchleds:
// synchronises each of the 20 inputs, debounces it, and emits press/change strobes.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sw_raw,
   input  logic [3:0]  btn_raw,
   output logic [15:0] sw_db,
   output logic [3:0]  btn_db,
   output logic [3:0]  btn_press,
   output logic        sw_chg
);

   localparam int CH = 20;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   // Buttons idle high: releasing reset with buttons untouched must not look like a press.
   localparam logic [CH-1:0] IDLE    = {4'hF, 16'h0000};
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [CH-1:0] raw;
   logic [CH-1:0] s;
   logic [CH-1:0] d;
   logic [CH-1:0] d_prev;
   logic [SYNC_STAGES-1:0][CH-1:0] sync_q;

   assign raw = {btn_raw, sw_raw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // One stability counter per channel; any cycle where s agrees with d restarts qualification.
   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          dq;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
            dq  <= IDLE[i];
         end else if (s[i] == dq) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            dq  <= s[i];
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end

      assign d[i] = dq;
   end

   // d_prev lags d by one cycle, so strobes land in the cycle after the level changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_prev    <= IDLE;
         btn_press <= '0;
         sw_chg    <= 1'b0;
      end else begin
         d_prev    <= d;
         btn_press <= d_prev[19:16] & ~d[19:16];
         sw_chg    <= |(d_prev[15:0] ^ d[15:0]);
      end
   end

   assign sw_db  = d[15:0];
   assign btn_db = d[19:16];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// level changes land after edge 6, strobes are high between edges 7 and 8.
module tb_input_conditioner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sw_raw = 16'h0000;
   logic [3:0]  btn_raw = 4'hF;
   logic [15:0] sw_db;
   logic [3:0]  btn_db;
   logic [3:0]  btn_press;
   logic        sw_chg;

   int checks = 0;
   int errs   = 0;

   bit [0:8] bounce;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw_raw(sw_raw),
      .btn_raw(btn_raw),
      .sw_db(sw_db),
      .btn_db(btn_db),
      .btn_press(btn_press),
      .sw_chg(sw_chg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge, so the next rising edge is edge 1.
   task automatic applyStimulus(input logic [15:0] sw, input logic [3:0] btn);
      @(negedge clk);
      sw_raw  = sw;
      btn_raw = btn;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Asynchronous reset between edges
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_sw_db", sw_db, 16'h0000);
      checkOutput("rst_btn_db", 16'(btn_db), 16'h000F);
      checkOutput("rst_btn_press", 16'(btn_press), 16'h0000);
      checkOutput("rst_sw_chg", 16'(sw_chg), 16'h0000);
      waitEdges(3);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         waitEdges(1);
         checkOutput("idle_btn_press", 16'(btn_press), 16'h0000);
         checkOutput("idle_sw_chg", 16'(sw_chg), 16'h0000);
         checkOutput("idle_btn_db", 16'(btn_db), 16'h000F);
      end

      // Clean switch change 0000 -> 00FF
      applyStimulus(16'h00FF, 4'hF);
      waitEdges(5);
      checkOutput("sw1_edge5", sw_db, 16'h0000);
      waitEdges(1);
      checkOutput("sw1_edge6", sw_db, 16'h00FF);
      checkOutput("sw1_chg_edge6", 16'(sw_chg), 16'h0000);
      waitEdges(1);
      checkOutput("sw1_chg_edge7", 16'(sw_chg), 16'h0001);
      waitEdges(1);
      checkOutput("sw1_chg_edge8", 16'(sw_chg), 16'h0000);

      // All 16 bits flip together 00FF -> FF00
      applyStimulus(16'hFF00, 4'hF);
      waitEdges(5);
      checkOutput("sw2_edge5", sw_db, 16'h00FF);
      waitEdges(1);
      checkOutput("sw2_edge6", sw_db, 16'hFF00);
      waitEdges(1);
      checkOutput("sw2_chg_edge7", 16'(sw_chg), 16'h0001);
      waitEdges(1);
      checkOutput("sw2_chg_edge8", 16'(sw_chg), 16'h0000);
      checkOutput("sw2_hold", sw_db, 16'hFF00);

      // Bounce on button 0: low pulses of 1, 2, 3 cycles must be rejected
      bounce = 9'b010010001;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(16'hFF00, {3'b111, bounce[i]});
         waitEdges(1);
         checkOutput("bounce_btn_db", 16'(btn_db), 16'h000F);
         checkOutput("bounce_btn_press", 16'(btn_press), 16'h0000);
      end
      applyStimulus(16'hFF00, 4'hE);
      waitEdges(5);
      checkOutput("press0_edge5", 16'(btn_db), 16'h000F);
      waitEdges(1);
      checkOutput("press0_edge6", 16'(btn_db), 16'h000E);
      checkOutput("press0_strobe_edge6", 16'(btn_press), 16'h0000);
      waitEdges(1);
      checkOutput("press0_strobe_edge7", 16'(btn_press), 16'h0001);
      waitEdges(1);
      checkOutput("press0_strobe_edge8", 16'(btn_press), 16'h0000);

      // Release: level returns, no strobe
      applyStimulus(16'hFF00, 4'hF);
      waitEdges(5);
      checkOutput("rel_edge5", 16'(btn_db), 16'h000E);
      waitEdges(1);
      checkOutput("rel_edge6", 16'(btn_db), 16'h000F);
      waitEdges(1);
      checkOutput("rel_strobe_edge7", 16'(btn_press), 16'h0000);
      waitEdges(1);
      checkOutput("rel_strobe_edge8", 16'(btn_press), 16'h0000);

      // Buttons 1 and 3 pressed together
      applyStimulus(16'hFF00, 4'b0101);
      waitEdges(6);
      checkOutput("dual_edge6", 16'(btn_db), 16'h0005);
      waitEdges(1);
      checkOutput("dual_strobe_edge7", 16'(btn_press), 16'h000A);
      waitEdges(1);
      checkOutput("dual_strobe_edge8", 16'(btn_press), 16'h0000);

      // Reset two cycles into qualification discards the partial count
      applyStimulus(16'h0000, 4'b0111);
      waitEdges(4);
      checkOutput("midrst_pre_btn", 16'(btn_db), 16'h0005);
      checkOutput("midrst_pre_sw", sw_db, 16'hFF00);
      #1 rst = 1'b1;
      #1;
      checkOutput("midrst_btn_db", 16'(btn_db), 16'h000F);
      checkOutput("midrst_sw_db", sw_db, 16'h0000);
      checkOutput("midrst_btn_press", 16'(btn_press), 16'h0000);
      checkOutput("midrst_sw_chg", 16'(sw_chg), 16'h0000);
      waitEdges(2);
      checkOutput("midrst_held_btn_db", 16'(btn_db), 16'h000F);
      @(negedge clk);
      rst = 1'b0;
      waitEdges(5);
      checkOutput("postrst_edge5", 16'(btn_db), 16'h000F);
      waitEdges(1);
      checkOutput("postrst_edge6", 16'(btn_db), 16'h0007);
      checkOutput("postrst_sw_db", sw_db, 16'h0000);
      waitEdges(1);
      checkOutput("postrst_strobe_edge7", 16'(btn_press), 16'h0008);
      checkOutput("postrst_sw_chg_edge7", 16'(sw_chg), 16'h0000);
      for (int i = 0; i < 8; i++) begin
         waitEdges(1);
         checkOutput("postrst_no_extra_press", 16'(btn_press), 16'h0000);
      end

      // Levels presented to switchleds after a held pattern
      applyStimulus(16'hFFFF, 4'b1110);
      waitEdges(6);
      checkOutput("down_sw_edge6", sw_db, 16'hFFFF);
      checkOutput("down_btn_edge6", 16'(btn_db), 16'h000E);
      waitEdges(1);
      checkOutput("down_press_edge7", 16'(btn_press), 16'h0001);
      checkOutput("down_chg_edge7", 16'(sw_chg), 16'h0001);
      waitEdges(3);
      checkOutput("down_sw_held", sw_db, 16'hFFFF);
      checkOutput("down_btn_held", 16'(btn_db), 16'h000E);
      checkOutput("down_press_held", 16'(btn_press), 16'h0000);
      checkOutput("down_chg_held", 16'(sw_chg), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end

endmodule
